// File: rtl/gray_capture_pkg.sv
// Shared definitions for the Gray-code capture path: bus width, debounce default, FSM encoding.
package gray_capture_pkg;

   localparam int unsigned GRAY_WIDTH              = 4;
   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;

   typedef enum logic {
      S_STABLE = 1'b0,
      S_SETTLE = 1'b1
   } state_t;

endpackage : gray_capture_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; output lags input by two clocks.
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule : sync_2ff

// File: rtl/gray_switch_capture.sv
// Synchronise, debounce and commit a raw Gray bus as one word, with a change strobe.
// Optional GRAY_STEP_CHECK_EN flags commits that move more than one bit.
module gray_switch_capture
   import gray_capture_pkg::*;
#(
   parameter int unsigned WIDTH           = GRAY_WIDTH,
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a_raw,
   output logic [WIDTH-1:0] gray_q,
   output logic             gray_valid,
   output logic             busy,
   output logic             step_err
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] cand;
   logic [CNT_W-1:0] cnt;
   state_t           state;
   logic             commit_c;

   sync_2ff #(.WIDTH(WIDTH)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (a_raw),
      .q     (sync_q)
   );

   // Candidate held for the full window and differs from the committed word
   assign commit_c = (state == S_SETTLE) && (sync_q == cand) &&
                     (cnt == CNT_LAST) && (cand != gray_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_STABLE;
         cand       <= '0;
         cnt        <= '0;
         gray_q     <= '0;
         gray_valid <= 1'b0;
         busy       <= 1'b0;
      end else begin
         gray_valid <= 1'b0;
         case (state)
            S_STABLE: begin
               if (sync_q != gray_q) begin
                  state <= S_SETTLE;
                  cand  <= sync_q;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            S_SETTLE: begin
               if (sync_q != cand) begin
                  cand <= sync_q;
                  cnt  <= '0;
               end else if (cnt == CNT_LAST) begin
                  // A glitch that settled back onto gray_q ends here silently
                  if (commit_c) begin
                     gray_q     <= cand;
                     gray_valid <= 1'b1;
                  end
                  state <= S_STABLE;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= S_STABLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef GRAY_STEP_CHECK_EN
   localparam int unsigned ONES_W = $clog2(WIDTH + 1);

   logic [ONES_W-1:0] step_ones_c;
   logic              step_err_q;

   // Number of bits that change between the committed word and the candidate
   always_comb begin
      step_ones_c = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         step_ones_c = step_ones_c + ONES_W'(cand[i] ^ gray_q[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_err_q <= 1'b0;
      end else begin
         step_err_q <= commit_c && (step_ones_c > ONES_W'(1));
      end
   end

   assign step_err = step_err_q;
`else
   assign step_err = 1'b0;
`endif

endmodule : gray_switch_capture

// File: tb/tb_gray_switch_capture.sv
// Bench for gray_switch_capture: run-length reference model plus directed literal checks.
module tb_gray_switch_capture;

   localparam int unsigned W = 4;
   localparam int unsigned D = 4;
`ifdef GRAY_STEP_CHECK_EN
   localparam bit STEP_EN = 1'b1;
`else
   localparam bit STEP_EN = 1'b0;
`endif

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] a_raw = '0;
   logic [W-1:0] gray_q;
   logic         gray_valid;
   logic         busy;
   logic         step_err;

   int errors = 0;
   int checks = 0;

   gray_switch_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .a_raw      (a_raw),
      .gray_q     (gray_q),
      .gray_valid (gray_valid),
      .busy       (busy),
      .step_err   (step_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the word seen by the debouncer is the raw input two edges
   // old; a new word is committed once it has been seen for D+1 consecutive edges.
   logic [W-1:0] raw_d1, raw_d2, seen, prev_seen, m_gray;
   int           run;
   bit           m_settle, m_valid, m_err;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         raw_d1 = '0; raw_d2 = '0; prev_seen = '0; m_gray = '0;
         run = 1; m_settle = 0; m_valid = 0; m_err = 0;
      end else begin
         seen   = raw_d2;
         raw_d2 = raw_d1;
         raw_d1 = a_raw;
         run    = (seen == prev_seen) ? run + 1 : 1;
         prev_seen = seen;
         m_valid = 0;
         m_err   = 0;
         if (!m_settle) begin
            m_settle = (seen != m_gray);
         end else if (run >= int'(D) + 1) begin
            if (seen != m_gray) begin
               m_err   = STEP_EN && ($countones(seen ^ m_gray) > 1);
               m_gray  = seen;
               m_valid = 1;
            end
            m_settle = 0;
         end
      end
   end

   // Per-cycle comparison against the model, plus event monitors for directed tests
   int valid_seen = 0, err_seen = 0, bad_vals = 0;
   bit busy_seen = 0, mon_vals = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         chk("gray_q", 32'(gray_q), 32'(m_gray));
         chk("gray_valid", 32'(gray_valid), 32'(m_valid));
         chk("busy", 32'(busy), 32'(m_settle));
         chk("step_err", 32'(step_err), 32'(m_err));
         if (gray_valid) valid_seen++;
         if (step_err) err_seen++;
         if (busy) busy_seen = 1;
         if (mon_vals && gray_q != 4'b0001 && gray_q != 4'b0011) bad_vals++;
      end
   end

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [W-1:0] v);
      @(negedge clk);
      a_raw = v;
   endtask

   task automatic hold(input logic [W-1:0] v, input int n);
      drive(v);
      edges(n);
   endtask

   initial begin
      // 1: reset, then idle with zero input
      edges(3);
      chk("t1_reset_gray_q", 32'(gray_q), 32'h0);
      chk("t1_reset_busy", 32'(busy), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      edges(20);
      chk("t1_idle_gray_q", 32'(gray_q), 32'h0);
      chk("t1_idle_busy", 32'(busy), 32'h0);
      chk("t1_idle_valid_cnt", 32'(valid_seen), 32'd0);

      // 2: single clean change, latency pinned edge by edge
      drive(4'b0001);
      edges(2);
      chk("t2_e2_busy", 32'(busy), 32'h0);
      edges(1);
      chk("t2_e3_busy", 32'(busy), 32'h1);
      edges(3);
      chk("t2_e6_busy", 32'(busy), 32'h1);
      chk("t2_e6_valid", 32'(gray_valid), 32'h0);
      chk("t2_e6_gray_q", 32'(gray_q), 32'h0);
      edges(1);
      chk("t2_e7_valid", 32'(gray_valid), 32'h1);
      chk("t2_e7_gray_q", 32'(gray_q), 32'h1);
      chk("t2_e7_busy", 32'(busy), 32'h0);
      edges(1);
      chk("t2_e8_valid", 32'(gray_valid), 32'h0);

      // 3: bouncing input settles on 0011, exactly one commit
      valid_seen = 0;
      mon_vals   = 1;
      for (int i = 0; i < 5; i++) begin
         hold((i % 2 == 0) ? 4'b0011 : 4'b0001, 2);
      end
      hold(4'b0011, 15);
      mon_vals = 0;
      chk("t3_valid_cnt", 32'(valid_seen), 32'd1);
      chk("t3_gray_q", 32'(gray_q), 32'h3);
      chk("t3_bad_vals", 32'(bad_vals), 32'd0);

      // 4: glitch away from 0001 and back, no commit
      hold(4'b0001, 12);
      valid_seen = 0;
      busy_seen  = 0;
      hold(4'b0011, 2);
      hold(4'b0001, 12);
      chk("t4_valid_cnt", 32'(valid_seen), 32'd0);
      chk("t4_busy_seen", 32'(busy_seen), 32'd1);
      chk("t4_gray_q", 32'(gray_q), 32'h1);
      chk("t4_busy_end", 32'(busy), 32'h0);

      // 5: two-bit jump, then a legal single-bit step
      hold(4'b0000, 12);
      err_seen = 0;
      valid_seen = 0;
      hold(4'b0101, 12);
      chk("t5_jump_valid_cnt", 32'(valid_seen), 32'd1);
      chk("t5_jump_err_cnt", 32'(err_seen), STEP_EN ? 32'd1 : 32'd0);
      chk("t5_jump_gray_q", 32'(gray_q), 32'h5);
      err_seen = 0;
      hold(4'b0100, 12);
      chk("t5_step_err_cnt", 32'(err_seen), 32'd0);
      chk("t5_step_gray_q", 32'(gray_q), 32'h4);

      // 6: asynchronous reset while settling, then recapture after release
      drive(4'b0010);
      edges(4);
      chk("t6_pre_busy", 32'(busy), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_gray_q", 32'(gray_q), 32'h0);
      chk("t6_rst_busy", 32'(busy), 32'h0);
      chk("t6_rst_valid", 32'(gray_valid), 32'h0);
      chk("t6_rst_step_err", 32'(step_err), 32'h0);
      a_raw = 4'b0110;
      @(negedge clk);
      rst_n = 1'b1;
      edges(6);
      chk("t6_e6_valid", 32'(gray_valid), 32'h0);
      chk("t6_e6_gray_q", 32'(gray_q), 32'h0);
      edges(1);
      chk("t6_e7_valid", 32'(gray_valid), 32'h1);
      chk("t6_e7_gray_q", 32'(gray_q), 32'h6);
      edges(4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_gray_switch_capture
